// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencing controller for the systolic-array top level.
// Runs one matrix pass per accepted start: weight load, weight push,
// activation load, compute with skew flush, and result drain.
// It drives the buffer and array enables only and never touches data.
// Optional feature macro: SA_CTRL_WEIGHT_REUSE_EN. When it is defined, a start
// with reuse_weight=1 skips the weight phases once a tile has been loaded.
module systolic_ctrl #(
    parameter int unsigned ARRAY_WIDTH = 4,
    parameter int unsigned ROW_CNT_W   = 8,
    parameter int unsigned PIPE_LAT    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROW_CNT_W-1:0] num_rows,
    input  logic                 reuse_weight,
    output logic                 busy,
    output logic                 done,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic                 a_valid,
    output logic                 a_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 weight_buffer_load_en,
    output logic                 weight_buffer_out_en,
    output logic                 write_weight_en,
    output logic                 input_buffer_load_en,
    output logic                 input_buffer_out_en,
    output logic                 output_buffer_load_en,
    output logic                 output_buffer_out_en
);

    // The counter must hold the longest phase, PIPE_LAT+M+N-1 at the largest M.
    localparam int unsigned MAX_ROWS = (1 << ROW_CNT_W) - 1;
    localparam int unsigned CNT_MAX  = PIPE_LAT + MAX_ROWS + ARRAY_WIDTH;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_LOAD  = 3'd1,
        S_W_PUSH  = 3'd2,
        S_A_LOAD  = 3'd3,
        S_COMPUTE = 3'd4,
        S_DRAIN   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [ROW_CNT_W-1:0] rows_q;
    logic [ROW_CNT_W-1:0] rows_d;

    // Phase end points, all derived from the latched row count.
    logic [CNT_W-1:0] rows_ext;
    logic [CNT_W-1:0] n_last;
    logic [CNT_W-1:0] m_last;
    logic [CNT_W-1:0] feed_last;
    logic [CNT_W-1:0] cap_first;
    logic [CNT_W-1:0] comp_last;

`ifdef SA_CTRL_WEIGHT_REUSE_EN
    logic tile_loaded_q;
    logic tile_loaded_d;
`else
    logic unused_reuse;
    assign unused_reuse = reuse_weight;
`endif

    // Phase boundary constants from the latched row count.
    always_comb begin
        rows_ext  = CNT_W'(rows_q);
        n_last    = CNT_W'(ARRAY_WIDTH - 1);
        m_last    = rows_ext - CNT_W'(1);
        feed_last = rows_ext + CNT_W'(ARRAY_WIDTH) - CNT_W'(2);
        cap_first = CNT_W'(PIPE_LAT);
        comp_last = cap_first + feed_last;
    end

    // State, counter and latched row-count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rows_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rows_q  <= rows_d;
        end
    end

`ifdef SA_CTRL_WEIGHT_REUSE_EN
    // Remembers that a weight tile sits in the array since the last reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tile_loaded_q <= 1'b0;
        end else begin
            tile_loaded_q <= tile_loaded_d;
        end
    end
`endif

    // Next-state, counter update and enable decode.
    always_comb begin
        state_d               = state_q;
        cnt_d                 = cnt_q;
        rows_d                = rows_q;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
        tile_loaded_d         = tile_loaded_q;
`endif
        busy                  = 1'b0;
        done                  = 1'b0;
        w_ready               = 1'b0;
        a_ready               = 1'b0;
        res_valid             = 1'b0;
        weight_buffer_load_en = 1'b0;
        weight_buffer_out_en  = 1'b0;
        write_weight_en       = 1'b0;
        input_buffer_load_en  = 1'b0;
        input_buffer_out_en   = 1'b0;
        output_buffer_load_en = 1'b0;
        output_buffer_out_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A zero-row start would have nothing to drain, so it is dropped.
                if (start && (num_rows != '0)) begin
                    rows_d  = num_rows;
                    cnt_d   = '0;
                    state_d = S_W_LOAD;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
                    if (reuse_weight && tile_loaded_q) begin
                        state_d = S_A_LOAD;
                    end
`endif
                end
            end

            S_W_LOAD: begin
                busy                  = 1'b1;
                w_ready               = 1'b1;
                weight_buffer_load_en = w_valid;
                if (w_valid) begin
                    if (cnt_q == n_last) begin
                        cnt_d   = '0;
                        state_d = S_W_PUSH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_W_PUSH: begin
                busy                 = 1'b1;
                weight_buffer_out_en = 1'b1;
                write_weight_en      = 1'b1;
                if (cnt_q == n_last) begin
                    cnt_d   = '0;
                    state_d = S_A_LOAD;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
                    tile_loaded_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_A_LOAD: begin
                busy                 = 1'b1;
                a_ready              = 1'b1;
                input_buffer_load_en = a_valid;
                if (a_valid) begin
                    if (cnt_q == m_last) begin
                        cnt_d   = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_COMPUTE: begin
                // Feed window covers M rows plus the N-1 cycle skew flush;
                // capture window is the same length shifted by the pipe latency.
                busy                  = 1'b1;
                input_buffer_out_en   = (cnt_q <= feed_last);
                output_buffer_load_en = (cnt_q >= cap_first);
                if (cnt_q == comp_last) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DRAIN: begin
                busy                 = 1'b1;
                res_valid            = 1'b1;
                output_buffer_out_en = res_ready;
                if (res_ready) begin
                    if (cnt_q == m_last) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: the expected enable vector of every
// cycle (or the expected beat counts of a stalled pass) is queued when the
// pass is started and popped as the DUT produces each cycle.
module tb_systolic_ctrl;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [RW-1:0] num_rows;
    logic          reuse_weight;
    logic          busy, done;
    logic          w_valid, w_ready, a_valid, a_ready, res_valid, res_ready;
    logic          weight_buffer_load_en, weight_buffer_out_en, write_weight_en;
    logic          input_buffer_load_en, input_buffer_out_en;
    logic          output_buffer_load_en, output_buffer_out_en;

    systolic_ctrl #(
        .ARRAY_WIDTH(N),
        .ROW_CNT_W  (RW),
        .PIPE_LAT   (P)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .num_rows             (num_rows),
        .reuse_weight         (reuse_weight),
        .busy                 (busy),
        .done                 (done),
        .w_valid              (w_valid),
        .w_ready              (w_ready),
        .a_valid              (a_valid),
        .a_ready              (a_ready),
        .res_valid            (res_valid),
        .res_ready            (res_ready),
        .weight_buffer_load_en(weight_buffer_load_en),
        .weight_buffer_out_en (weight_buffer_out_en),
        .write_weight_en      (write_weight_en),
        .input_buffer_load_en (input_buffer_load_en),
        .input_buffer_out_en  (input_buffer_out_en),
        .output_buffer_load_en(output_buffer_load_en),
        .output_buffer_out_en (output_buffer_out_en)
    );

    always #5 clk = ~clk;

    // Observed vector: busy done w_rdy a_rdy res_v wbl wbo ww ibl ibo obl obo
    logic [11:0] obs;
    assign obs = {busy, done, w_ready, a_ready, res_valid,
                  weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
                  input_buffer_load_en, input_buffer_out_en,
                  output_buffer_load_en, output_buffer_out_en};

    int          checks = 0;
    int          errors = 0;
    logic [11:0] sb[$];
    int          cnt_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected enables at cycle t after the start edge, all handshakes high.
    function automatic logic [11:0] exp_vec(input int t, input int m, input bit skip);
        int nw, b1, b2, b3, b4, b5, c;
        logic [11:0] v;
        nw = skip ? 0 : N;
        b1 = 1 + nw;
        b2 = b1 + nw;
        b3 = b2 + m;
        b4 = b3 + (P + m + N - 1);
        b5 = b4 + m;
        v  = '0;
        if (t >= 1 && t < b1) begin
            v[11] = 1'b1; v[9] = 1'b1; v[6] = 1'b1;
        end else if (t >= b1 && t < b2) begin
            v[11] = 1'b1; v[5] = 1'b1; v[4] = 1'b1;
        end else if (t >= b2 && t < b3) begin
            v[11] = 1'b1; v[8] = 1'b1; v[3] = 1'b1;
        end else if (t >= b3 && t < b4) begin
            c     = t - b3;
            v[11] = 1'b1;
            v[2]  = (c <= m + N - 2);
            v[1]  = (c >= P);
        end else if (t >= b4 && t < b5) begin
            v[11] = 1'b1; v[7] = 1'b1; v[0] = 1'b1;
        end else if (t == b5) begin
            v[11] = 1'b1; v[10] = 1'b1;
        end
        return v;
    endfunction

    // Zero-stall pass checked cycle by cycle; optional stray start / reset.
    task automatic run_pass(input int m, input bit reuse, input bit skip,
                            input int pulse_at, input int rst_at);
        int len;
        logic [11:0] e;
        len = (skip ? 0 : 2 * N) + m + (P + m + N - 1) + m + 1;
        @(negedge clk);
        start = 1'b1; num_rows = RW'(m); reuse_weight = reuse;
        w_valid = 1'b1; a_valid = 1'b1; res_ready = 1'b1;
        for (int t = 1; t <= len + 1; t++) begin
            if (rst_at != 0 && t > rst_at) sb.push_back('0);
            else                            sb.push_back(exp_vec(t, m, skip));
        end
        for (int t = 1; t <= len + 1; t++) begin
            @(negedge clk);
            start    = 1'b0;
            num_rows = '0;
            rst      = (t == rst_at) ? 1'b0 : 1'b1;
            if (t == pulse_at) begin
                start = 1'b1; num_rows = RW'(3);
            end
            #1;
            e = sb.pop_front();
            check($sformatf("pass_m%0d_t%0d", m, t), 32'(obs), 32'(e));
        end
    endtask

    // Stalled pass: valids toggle, res_ready low on alternate cycles.
    task automatic run_bp(input int m);
        int wl, il, oo, dn, ww;
        bit seen;
        wl = 0; il = 0; oo = 0; dn = 0; ww = 0; seen = 1'b0;
        @(negedge clk);
        start = 1'b1; num_rows = RW'(m); reuse_weight = 1'b0;
        cnt_q.push_back(N); cnt_q.push_back(m); cnt_q.push_back(m);
        cnt_q.push_back(1); cnt_q.push_back(N);
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            start     = 1'b0;
            w_valid   = (k % 2 == 0);
            a_valid   = (k % 2 == 0);
            res_ready = (k % 2 == 1);
            #1;
            wl += int'(weight_buffer_load_en);
            il += int'(input_buffer_load_en);
            oo += int'(output_buffer_out_en);
            ww += int'(write_weight_en);
            if (done) begin
                dn++;
                seen = 1'b1;
            end
        end
        check("bp_timeout", 32'(seen), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            dn += int'(done);
        end
        check("bp_w_loads",  32'(wl), 32'(cnt_q.pop_front()));
        check("bp_a_loads",  32'(il), 32'(cnt_q.pop_front()));
        check("bp_res_outs", 32'(oo), 32'(cnt_q.pop_front()));
        check("bp_done",     32'(dn), 32'(cnt_q.pop_front()));
        check("bp_ww",       32'(ww), 32'(cnt_q.pop_front()));
        w_valid = 1'b1; a_valid = 1'b1; res_ready = 1'b1;
    endtask

    initial begin
        bit skip_reuse;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
        skip_reuse = 1'b1;
`else
        skip_reuse = 1'b0;
`endif
        rst = 1'b0; start = 1'b0; num_rows = '0; reuse_weight = 1'b0;
        w_valid = 1'b1; a_valid = 1'b1; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 32'(obs), 32'd0);
        rst = 1'b1;

        // Full pass M=6, stray start in A_LOAD, num_rows dropped after accept.
        run_pass(6, 1'b0, 1'b0, 10, 0);

        // num_rows=0 start is ignored.
        @(negedge clk);
        start = 1'b1; num_rows = '0;
        for (int t = 1; t <= 4; t++) begin
            sb.push_back('0);
        end
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check($sformatf("zero_rows_t%0d", t), 32'(obs), 32'(sb.pop_front()));
        end

        run_bp(6);

        // Reset on the 5th COMPUTE cycle (cycle 19) aborts the pass.
        run_pass(6, 1'b0, 1'b0, 0, 19);

        // First pass after reset loads weights even with reuse requested.
        run_pass(6, 1'b1, 1'b0, 0, 0);
        // Second reuse pass skips weights only when the feature is built in.
        run_pass(3, 1'b1, skip_reuse, 0, 0);

        // Largest row count: COMPUTE spans 262 cycles, 255 drain beats.
        run_pass(255, 1'b0, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for the systolic-array top level. On a `start` command it runs one complete matrix pass:
- loads a weight tile into the weight buffer, then pushes it into the array;
- loads an activation stream into the input buffer, then streams it through the array;
- captures the results into the output buffer and drains them to the consumer with a valid/ready handshake.

It drives every buffer and array enable of the top level. It never touches data.

## Interface
- `ARRAY_WIDTH`, default 4: array rows/columns (N); number of weight beats per tile.
- `ROW_CNT_W`, default 8: width of the activation row count (M).
- `PIPE_LAT`, default 4: cycles from the first `input_buffer_out_en` until the first result row is valid at the output buffer input.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `num_rows`  in  ROW_CNT_W  M, activation rows this pass; latched on accepted start.
- `reuse_weight`  in  1  skip the weight phases (macro-dependent).
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at pass completion.
- `w_valid` / `w_ready`  in/out  1  weight beat handshake.
- `a_valid` / `a_ready`  in/out  1  activation beat handshake.
- `res_valid` / `res_ready`  out/in  1  result beat handshake.
- `weight_buffer_load_en`, `weight_buffer_out_en`, `write_weight_en`  out  1  weight path enables.
- `input_buffer_load_en`, `input_buffer_out_en`  out  1  activation path enables.
- `output_buffer_load_en`, `output_buffer_out_en`  out  1  result path enables.

## Operation
- States: IDLE → W_LOAD → W_PUSH → A_LOAD → COMPUTE → DRAIN → DONE → IDLE.
- IDLE
  - `start=1` with `num_rows≠0`: latch M, go to W_LOAD.
  - `start=1` with `num_rows=0`: ignored; stay in IDLE, no `done`.
- W_LOAD
  - `w_ready=1`; `weight_buffer_load_en = w_valid`.
  - Exit after N accepted beats (`w_valid & w_ready`).
- W_PUSH
  - `weight_buffer_out_en=1` and `write_weight_en=1` for exactly N cycles.
- A_LOAD
  - `a_ready=1`; `input_buffer_load_en = a_valid`.
  - Exit after M accepted beats.
- COMPUTE: cycle counter c runs from 0 to PIPE_LAT+M+N−2.
  - `input_buffer_out_en=1` for c in [0, M+N−2], which covers the skew flush.
  - `output_buffer_load_en=1` for c in [PIPE_LAT, PIPE_LAT+M+N−2].
- DRAIN
  - `res_valid=1` and `output_buffer_out_en = res_ready`.
  - Exit after M accepted beats. `res_ready` low stalls with no beat lost.
- DONE: `done=1` for one cycle, then IDLE.
- Enables are asserted only in the states listed above; they are 0 everywhere else.
- Counters are sized to hold max(N, PIPE_LAT+M+N−1) with no wrap. M=2^ROW_CNT_W−1 must work.
- `start` outside IDLE is ignored; `num_rows` changes after acceptance have no effect.

## Timing
- Reset (`rst=0` at an edge): state IDLE, all counters 0. The following outputs are 0 from the next cycle: `busy`, `done`, all ready, `res_valid` and all enables.
- Reset mid-pass aborts immediately. There is no `done` and no partial drain.
- All outputs are registered or decoded purely from registered state (no input-to-output paths), except these combinational gates:
  - `weight_buffer_load_en = w_valid & state`;
  - `input_buffer_load_en = a_valid & state`;
  - `output_buffer_out_en = res_ready & state`.
- Start latency: start accepted at edge k → first W_LOAD cycle k+1.
- Zero-stall pass length: N + N + M + (PIPE_LAT+M+N−1) + M cycles, then 1 DONE cycle.
- State transitions occur at the edge that completes the last beat or cycle of a phase. There are no idle bubbles between phases.

## Configuration
- `SA_CTRL_WEIGHT_REUSE_EN` defined
  - `start` with `reuse_weight=1` goes IDLE → A_LOAD; `w_ready` stays 0 for the whole pass.
  - `start` with `reuse_weight=1` while no tile has been loaded since reset executes a full pass. A tile-loaded flag is set at W_PUSH exit and cleared by reset.
- `SA_CTRL_WEIGHT_REUSE_EN` not defined: `reuse_weight` is ignored; every pass includes W_LOAD and W_PUSH.

## Test plan
- Full pass, N=4, PIPE_LAT=4, M=6, all valids and readies held high, start at edge 0:
  - W_LOAD cycles 1–4, W_PUSH 5–8, A_LOAD 9–14, COMPUTE 15–27, DRAIN 28–33, `done` at cycle 34.
  - `input_buffer_out_en` high on cycles 15–23; `output_buffer_load_en` high on 19–27.
- Backpressure: `w_valid`/`a_valid` toggle 1010…, and `res_ready` is low on alternate DRAIN cycles. Required: exactly 4 weight loads, 6 activation loads, 6 `output_buffer_out_en` pulses; `done` once.
- Reset asserted on the 5th COMPUTE cycle → next cycle all outputs 0, `busy=0`; a new start runs a clean full pass.
- `start` with `num_rows=0` → `busy` stays 0, no `done`. `start` pulsed during A_LOAD → ignored; pass length unchanged.
- With `SA_CTRL_WEIGHT_REUSE_EN` defined:
  - second pass with `reuse_weight=1` enters A_LOAD one cycle after start; `write_weight_en` never asserts;
  - first pass after reset with `reuse_weight=1` loads weights.
- Max rows, M=255 → COMPUTE lasts exactly 262 cycles (N=4, PIPE_LAT=4), 255 DRAIN beats, no counter wrap.
